// File: rtl/lsb_steg_pkg.sv
// Shared definitions for the LSB steganography embedder/extractor pair.
// Both ends agree on sample width, word size, bit order (MSB-first) and FSM encoding.
package lsb_steg_pkg;

    localparam int BPS_DEF   = 24;
    localparam int MSG_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXTRACT = 2'd1
    } lsb_state_e;

endpackage

// File: rtl/lsb_message_extractor.sv
// Recovers the LSB of each accepted stego sample and packs the bits MSB-first
// into MSG_W-bit message words. Accepts at most one sample every two clocks.
module lsb_message_extractor
    import lsb_steg_pkg::*;
#(
    parameter int BPS   = BPS_DEF,
    parameter int MSG_W = MSG_W_DEF
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_enable,
    input  logic             in_sync,
    input  logic [BPS-1:0]   in_frame,
    output logic             out_bit,
    output logic             out_bit_ready,
    output logic [MSG_W-1:0] out_message,
    output logic             out_ready,
    output logic             out_busy
);

    localparam int            CW   = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(MSG_W - 1);

    lsb_state_e       r_state,   w_state_nxt;
    logic             r_bit_in,  w_bit_in_nxt;
    logic [MSG_W-1:0] r_shift,   w_shift_nxt;
    logic [CW-1:0]    r_cnt,     w_cnt_nxt;
    logic             r_bit,     w_bit_nxt;
    logic             r_bit_rdy, w_bit_rdy_nxt;
    logic [MSG_W-1:0] r_msg,     w_msg_nxt;
    logic             r_rdy,     w_rdy_nxt;
    logic [MSG_W-1:0] w_shifted;
    logic             w_unused_upper;

    // Only the LSB carries message data; the audio payload is deliberately ignored.
    assign w_unused_upper = ^in_frame[BPS-1:1];
    assign w_shifted      = {r_shift[MSG_W-2:0], r_bit_in};

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state   <= IDLE;
            r_bit_in  <= 1'b0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_bit     <= 1'b0;
            r_bit_rdy <= 1'b0;
            r_msg     <= '0;
            r_rdy     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_in  <= w_bit_in_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_bit_rdy <= w_bit_rdy_nxt;
            r_msg     <= w_msg_nxt;
            r_rdy     <= w_rdy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_in_nxt  = r_bit_in;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_bit_rdy_nxt = 1'b0;
        w_msg_nxt     = r_msg;
        w_rdy_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                // Sync wins over a simultaneous strobe so realignment is never lost.
                if (in_sync) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end else if (in_enable) begin
                    w_bit_in_nxt = in_frame[0];
                    w_state_nxt  = EXTRACT;
                end
            end
            EXTRACT: begin
                w_shift_nxt   = w_shifted;
                w_bit_nxt     = r_bit_in;
                w_bit_rdy_nxt = 1'b1;
                if (r_cnt == LAST) begin
                    w_msg_nxt = w_shifted;
                    w_rdy_nxt = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_bit       = r_bit;
    assign out_bit_ready = r_bit_rdy;
    assign out_message   = r_msg;
    assign out_ready     = r_rdy;
    assign out_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_lsb_message_extractor.sv
// Self-checking bench for lsb_message_extractor: vector table, corner-case
// sequences, randomized run against a queue-based model, and embedder loopback.
module tb_lsb_message_extractor;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_enable;
    logic        in_sync;
    logic [23:0] in_frame;
    logic        out_bit;
    logic        out_bit_ready;
    logic [7:0]  out_message;
    logic        out_ready;
    logic        out_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 in_clk = ~in_clk;

    lsb_message_extractor #(.BPS(24), .MSG_W(8)) dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .in_enable     (in_enable),
        .in_sync       (in_sync),
        .in_frame      (in_frame),
        .out_bit       (out_bit),
        .out_bit_ready (out_bit_ready),
        .out_message   (out_message),
        .out_ready     (out_ready),
        .out_busy      (out_busy)
    );

    typedef struct {
        logic [23:0] frame;
        logic        exp_bit;
        logic        exp_rdy;
        logic [7:0]  exp_msg;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // One strobe in IDLE, then the EXTRACT edge; returns at #1 after the EXTRACT edge.
    task automatic send_sample(input logic [23:0] f);
        in_enable = 1'b1;
        in_frame  = f;
        @(posedge in_clk); #1;
        in_enable = 1'b0;
        in_frame  = $urandom();
        check("busy_after_accept", {31'd0, out_busy}, 32'd1);
        @(posedge in_clk); #1;
    endtask

    function automatic logic [23:0] mkframe(input logic b);
        logic [23:0] r;
        r    = $urandom();
        r[0] = b;
        return r;
    endfunction

    // Randomized model state
    logic       m_pend, m_pbit, m_last, m_brdy, m_rdy;
    logic [7:0] m_msg;
    logic       q_bits[$];
    logic       r_en, r_sy;
    logic [23:0] r_fr;
    logic [7:0] pat, held, lb_msg[64], word;

    initial begin
        in_rst_n  = 1'b0;
        in_enable = 1'b0;
        in_sync   = 1'b0;
        in_frame  = '0;
        #12;
        check("reset_outputs", {19'd0, out_busy, out_bit, out_bit_ready, out_ready, out_message},
              32'd0);
        #10 in_rst_n = 1'b1;
        @(posedge in_clk); #1;

        // Table: A5 with random upper bits, 5A with upper all-0, 5A with upper all-1
        held = 8'h00;
        for (int s = 0; s < 3; s++) begin
            pat = (s == 0) ? 8'hA5 : 8'h5A;
            for (int j = 0; j < 8; j++) begin
                vecs[s*8+j].frame   = (s == 0) ? mkframe(pat[7-j]) :
                                      (s == 1) ? {23'h000000, pat[7-j]} : {23'h7FFFFF, pat[7-j]};
                vecs[s*8+j].exp_bit = pat[7-j];
                vecs[s*8+j].exp_rdy = (j == 7);
                if (j == 7) held = pat;
                vecs[s*8+j].exp_msg = held;
            end
        end
        for (int i = 0; i < 24; i++) begin
            send_sample(vecs[i].frame);
            check("tbl_bit",     {31'd0, out_bit},       {31'd0, vecs[i].exp_bit});
            check("tbl_bit_rdy", {31'd0, out_bit_ready}, 32'd1);
            check("tbl_ready",   {31'd0, out_ready},     {31'd0, vecs[i].exp_rdy});
            check("tbl_msg",     {24'd0, out_message},   {24'd0, vecs[i].exp_msg});
        end
        @(posedge in_clk); #1;
        check("pulse_clear", {30'd0, out_bit_ready, out_ready}, 32'd0);
        check("msg_held",    {24'd0, out_message}, 32'h5A);

        // Strobe held high: acceptance on alternate edges
        pat = 8'h3C;
        in_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_frame = mkframe(pat[7-i/2]);
            @(posedge in_clk); #1;
            check("hold_busy", {31'd0, out_busy}, {31'd0, (i % 2 == 0)});
            if (i % 2 == 1) begin
                check("hold_bit", {30'd0, out_bit_ready, out_bit}, {30'd0, 1'b1, pat[7-i/2]});
                check("hold_rdy", {31'd0, out_ready}, {31'd0, (i == 15)});
            end
        end
        in_enable = 1'b0;
        check("hold_msg", {24'd0, out_message}, 32'h3C);

        // Partial word, then sync, then a fresh aligned word
        for (int i = 0; i < 3; i++) begin
            send_sample(mkframe($urandom()));
            check("sync_pre_msg", {24'd0, out_message}, 32'h3C);
        end
        in_sync   = 1'b1;
        in_enable = 1'b1;
        @(posedge in_clk); #1;
        in_sync   = 1'b0;
        in_enable = 1'b0;
        check("sync_prio_busy", {31'd0, out_busy}, 32'd0);
        check("sync_keeps_msg", {24'd0, out_message}, 32'h3C);
        pat = 8'h81;
        for (int j = 0; j < 8; j++) begin
            send_sample(mkframe(pat[7-j]));
            check("sync_msg", {24'd0, out_message}, (j == 7) ? 32'h81 : 32'h3C);
            check("sync_rdy", {31'd0, out_ready}, {31'd0, (j == 7)});
        end

        // Async reset while in EXTRACT
        for (int i = 0; i < 5; i++) send_sample(mkframe($urandom()));
        in_enable = 1'b1;
        in_frame  = mkframe(1'b1);
        @(posedge in_clk); #1;
        in_enable = 1'b0;
        check("rst_pre_busy", {31'd0, out_busy}, 32'd1);
        #2 in_rst_n = 1'b0;
        #1;
        check("rst_async", {19'd0, out_busy, out_bit, out_bit_ready, out_ready, out_message}, 32'd0);
        @(posedge in_clk); #1;
        in_rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            send_sample(mkframe(1'b1));
            check("rst_msg", {24'd0, out_message}, (j == 7) ? 32'hFF : 32'h00);
        end

        // Randomized run against a queue-of-bits model
        m_pend = 1'b0; m_pbit = 1'b0; m_last = 1'b1; m_msg = 8'hFF;
        q_bits.delete();
        for (int c = 0; c < 600; c++) begin
            r_en = ($urandom_range(2) != 0);
            r_sy = ($urandom_range(7) == 0);
            r_fr = $urandom();
            in_enable = r_en; in_sync = r_sy; in_frame = r_fr;
            @(posedge in_clk); #1;
            m_brdy = 1'b0; m_rdy = 1'b0;
            if (m_pend) begin
                q_bits.push_back(m_pbit);
                m_last = m_pbit; m_brdy = 1'b1; m_pend = 1'b0;
                if (q_bits.size() == 8) begin
                    foreach (q_bits[k]) m_msg = {m_msg[6:0], q_bits[k]};
                    m_rdy = 1'b1;
                    q_bits.delete();
                end
            end else if (r_sy) q_bits.delete();
            else if (r_en) begin m_pend = 1'b1; m_pbit = r_fr[0]; end
            check("random", {20'd0, out_busy, out_bit_ready, out_ready, out_bit, out_message},
                  {20'd0, m_pend, m_brdy, m_rdy, m_last, m_msg});
        end
        in_enable = 1'b0; in_sync = 1'b0;
        @(posedge in_clk); #1;

        // Loopback: embed a random 64-byte message MSB-first, recover in order
        in_sync = 1'b1;
        @(posedge in_clk); #1;
        in_sync = 1'b0;
        for (int b = 0; b < 64; b++) lb_msg[b] = $urandom();
        for (int b = 0; b < 64; b++) begin
            word = lb_msg[b];
            for (int j = 0; j < 8; j++) send_sample(mkframe(word[7-j]));
            check("loopback", {23'd0, out_ready, out_message}, {23'd0, 1'b1, lb_msg[b]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
